// File: rtl/conv_out_addr_gen_if.sv
// Signal bundle between the MAC array, conv_out_addr_gen and the output feature-map RAM.
// The slave modport is the controller side; master is whoever drives start/mac_valid.
interface conv_out_addr_gen_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              start;
   logic              mac_valid;
   logic              neuron_rdy;
   logic [ADDR_W-1:0] out_addr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              plane_done;
   logic              layer_done;
   logic              busy;
   logic [7:0]        ch_idx;

   modport master (
      output start,
      output mac_valid,
      input  neuron_rdy,
      input  out_addr,
      input  wr_en,
      input  wr_addr,
      input  plane_done,
      input  layer_done,
      input  busy,
      input  ch_idx
   );

   modport slave (
      input  start,
      input  mac_valid,
      output neuron_rdy,
      output out_addr,
      output wr_en,
      output wr_addr,
      output plane_done,
      output layer_done,
      output busy,
      output ch_idx
   );
endinterface

// File: rtl/conv_out_addr_gen.sv
// Output-side controller of the conv engine: counts MAC beats per neuron, generates
// channel-major output addresses and a delayed write strobe for the output RAM.
module conv_out_addr_gen #(
   parameter int unsigned ACC_CYCLES   = 25,
   parameter int unsigned PLANE_PIXELS = 196,
   parameter int unsigned OUT_CHANNELS = 16,
   parameter int unsigned WR_DELAY     = 2,
   parameter int unsigned ADDR_W       = 16
) (
   input logic                clk,
   input logic                rst_n,
   conv_out_addr_gen_if.slave bus
);

   localparam int unsigned AccW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam longint unsigned Total = longint'(OUT_CHANNELS) * longint'(PLANE_PIXELS);

   localparam logic [AccW-1:0]   AccLast   = AccW'(ACC_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LastPix   = ADDR_W'(PLANE_PIXELS - 1);
   localparam logic [ADDR_W-1:0] PlaneStep = ADDR_W'(PLANE_PIXELS);
   localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(Total - 1);
   localparam logic [7:0]        LastCh    = 8'(OUT_CHANNELS - 1);

   if (ACC_CYCLES < 1 || PLANE_PIXELS < 1 || OUT_CHANNELS < 1 || WR_DELAY < 1) begin : g_param_chk
      $fatal(1, "conv_out_addr_gen: ACC_CYCLES, PLANE_PIXELS, OUT_CHANNELS, WR_DELAY must be >= 1");
   end
   if (((Total - 1) >> ADDR_W) != 0) begin : g_addr_w_chk
      $fatal(1, "conv_out_addr_gen: ADDR_W too small for OUT_CHANNELS*PLANE_PIXELS-1");
   end
   if (OUT_CHANNELS > 256) begin : g_ch_w_chk
      $fatal(1, "conv_out_addr_gen: OUT_CHANNELS does not fit the 8-bit ch_idx");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [AccW-1:0]   acc_q, acc_d;
   logic [ADDR_W-1:0] pix_q, pix_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [7:0]        ch_q, ch_d;
   logic              rdy_q, rdy_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic              plast_q, plast_d;

   logic [WR_DELAY-1:0] pipe_vld_q;
   logic [WR_DELAY-1:0] pipe_pl_q;
   logic [ADDR_W-1:0]   pipe_addr_q [WR_DELAY];

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;

   assign wr_en   = pipe_vld_q[WR_DELAY-1];
   assign wr_addr = pipe_addr_q[WR_DELAY-1];

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      pix_d      = pix_q;
      base_d     = base_q;
      ch_d       = ch_q;
      rdy_d      = 1'b0;
      out_addr_d = out_addr_q;
      plast_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A mac_valid in the same cycle as start is dropped on purpose.
            if (bus.start) begin
               state_d = StRun;
               acc_d   = '0;
               pix_d   = '0;
               base_d  = '0;
               ch_d    = '0;
            end
         end
         StRun: begin
            if (bus.mac_valid) begin
               if (acc_q == AccLast) begin
                  acc_d      = '0;
                  rdy_d      = 1'b1;
                  out_addr_d = base_q + pix_q;
                  plast_d    = (pix_q == LastPix);
                  if (pix_q == LastPix) begin
                     // Counters hold on the final neuron so ch_idx keeps the last channel.
                     if (ch_q == LastCh) begin
                        state_d = StDrain;
                     end else begin
                        pix_d  = '0;
                        ch_d   = ch_q + 8'd1;
                        base_d = base_q + PlaneStep;
                     end
                  end else begin
                     pix_d = pix_q + ADDR_W'(1);
                  end
               end else begin
                  acc_d = acc_q + AccW'(1);
               end
            end
         end
         StDrain: begin
            if (wr_en && (wr_addr == LastAddr)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         pix_q      <= '0;
         base_q     <= '0;
         ch_q       <= '0;
         rdy_q      <= 1'b0;
         out_addr_q <= '0;
         plast_q    <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         pix_q      <= pix_d;
         base_q     <= base_d;
         ch_q       <= ch_d;
         rdy_q      <= rdy_d;
         out_addr_q <= out_addr_d;
         plast_q    <= plast_d;
      end
   end

   // Write pipe mirrors the MAC drain latency; one slot per cycle keeps full rate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld_q <= '0;
         pipe_pl_q  <= '0;
         for (int i = 0; i < WR_DELAY; i++) begin
            pipe_addr_q[i] <= '0;
         end
      end else begin
         pipe_vld_q[0]  <= rdy_q;
         pipe_pl_q[0]   <= plast_q;
         pipe_addr_q[0] <= out_addr_q;
         for (int i = 1; i < WR_DELAY; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_pl_q[i]   <= pipe_pl_q[i-1];
            pipe_addr_q[i] <= pipe_addr_q[i-1];
         end
      end
   end

   assign bus.neuron_rdy = rdy_q;
   assign bus.out_addr   = out_addr_q;
   assign bus.wr_en      = wr_en;
   assign bus.wr_addr    = wr_addr;
   assign bus.plane_done = wr_en & pipe_pl_q[WR_DELAY-1];
   assign bus.layer_done = (state_q == StDone);
   assign bus.busy       = (state_q == StRun) || (state_q == StDrain);
   assign bus.ch_idx     = (state_q == StIdle) ? 8'd0 : ch_q;

   a_rdy_in_layer: assert property (@(posedge clk) disable iff (!rst_n)
      rdy_q |-> (state_q inside {StRun, StDrain}));
   a_wr_in_layer: assert property (@(posedge clk) disable iff (!rst_n)
      wr_en |-> (state_q inside {StRun, StDrain}));
   a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == StDone) |=> (state_q == StIdle));

endmodule

// File: tb/tb_conv_out_addr_gen.sv
// Bench for conv_out_addr_gen: three instances (small, single-beat, full-size plane)
// compared cycle by cycle against an event-schedule model of the layer.
module tb_conv_out_addr_gen;

   localparam int NDUT = 3;
   localparam int AW   = 16;
   localparam int WD   = 2;

   function automatic int acc_of(input int d);
      case (d)
         0:       return 3;
         1:       return 1;
         default: return 4;  // short accumulate keeps the full-size layer run brief
      endcase
   endfunction

   function automatic int pp_of(input int d);
      return (d == 2) ? 196 : 4;
   endfunction

   function automatic int oc_of(input int d);
      return (d == 2) ? 16 : 2;
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_v  [NDUT];
   logic          st_v   [NDUT];
   logic          mv_v   [NDUT];
   logic          rdy_v  [NDUT];
   logic [AW-1:0] oaddr_v[NDUT];
   logic          wr_v   [NDUT];
   logic [AW-1:0] waddr_v[NDUT];
   logic          pd_v   [NDUT];
   logic          ld_v   [NDUT];
   logic          busy_v [NDUT];
   logic [7:0]    ch_v   [NDUT];

   conv_out_addr_gen_if #(.ADDR_W(AW)) bus0 ();
   conv_out_addr_gen_if #(.ADDR_W(AW)) bus1 ();
   conv_out_addr_gen_if #(.ADDR_W(AW)) bus2 ();

   conv_out_addr_gen #(
      .ACC_CYCLES(3), .PLANE_PIXELS(4), .OUT_CHANNELS(2), .WR_DELAY(WD), .ADDR_W(AW)
   ) u_dut_small (.clk(clk), .rst_n(rst_v[0]), .bus(bus0));

   conv_out_addr_gen #(
      .ACC_CYCLES(1), .PLANE_PIXELS(4), .OUT_CHANNELS(2), .WR_DELAY(WD), .ADDR_W(AW)
   ) u_dut_fast (.clk(clk), .rst_n(rst_v[1]), .bus(bus1));

   conv_out_addr_gen #(
      .ACC_CYCLES(4), .PLANE_PIXELS(196), .OUT_CHANNELS(16), .WR_DELAY(WD), .ADDR_W(AW)
   ) u_dut_full (.clk(clk), .rst_n(rst_v[2]), .bus(bus2));

   assign bus0.start = st_v[0];
   assign bus1.start = st_v[1];
   assign bus2.start = st_v[2];
   assign bus0.mac_valid = mv_v[0];
   assign bus1.mac_valid = mv_v[1];
   assign bus2.mac_valid = mv_v[2];

   assign rdy_v[0] = bus0.neuron_rdy;  assign rdy_v[1] = bus1.neuron_rdy;
   assign rdy_v[2] = bus2.neuron_rdy;
   assign oaddr_v[0] = bus0.out_addr;  assign oaddr_v[1] = bus1.out_addr;
   assign oaddr_v[2] = bus2.out_addr;
   assign wr_v[0] = bus0.wr_en;        assign wr_v[1] = bus1.wr_en;
   assign wr_v[2] = bus2.wr_en;
   assign waddr_v[0] = bus0.wr_addr;   assign waddr_v[1] = bus1.wr_addr;
   assign waddr_v[2] = bus2.wr_addr;
   assign pd_v[0] = bus0.plane_done;   assign pd_v[1] = bus1.plane_done;
   assign pd_v[2] = bus2.plane_done;
   assign ld_v[0] = bus0.layer_done;   assign ld_v[1] = bus1.layer_done;
   assign ld_v[2] = bus2.layer_done;
   assign busy_v[0] = bus0.busy;       assign busy_v[1] = bus1.busy;
   assign busy_v[2] = bus2.busy;
   assign ch_v[0] = bus0.ch_idx;       assign ch_v[1] = bus1.ch_idx;
   assign ch_v[2] = bus2.ch_idx;

   // Model: counted beats per neuron, neuron index, and a schedule of expected writes.
   bit run_m      [NDUT];
   int beats_m    [NDUT];
   int nidx_m     [NDUT];
   int idle_from_m[NDUT];
   int busy_til_m [NDUT];
   int ld_at_m    [NDUT];
   int wq_due     [NDUT][16];
   int wq_adr     [NDUT][16];
   int wq_hd      [NDUT];
   int wq_tl      [NDUT];

   int wr_cnt [NDUT];
   int pd_cnt [NDUT];
   int ld_cnt [NDUT];
   int last_wr[NDUT];

   int cyc      = 0;
   int cur_dut  = 0;
   int n_checks = 0;
   int n_errs   = 0;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_errs++;
         $display("FAIL %s dut=%0d cycle=%0d: got %0d, expected %0d", tag, cur_dut, cyc, obs, exp);
      end
   endtask

   task automatic model_reset(input int d);
      run_m[d]       = 1'b0;
      beats_m[d]     = 0;
      nidx_m[d]      = 0;
      idle_from_m[d] = 0;
      busy_til_m[d]  = -1;
      ld_at_m[d]     = -1;
      wq_hd[d]       = 0;
      wq_tl[d]       = 0;
   endtask

   task automatic check_all_zero(input int d, input string tag);
      check_eq({tag, "_rdy"}, longint'(rdy_v[d]), 0);
      check_eq({tag, "_oaddr"}, longint'(oaddr_v[d]), 0);
      check_eq({tag, "_wr"}, longint'(wr_v[d]), 0);
      check_eq({tag, "_waddr"}, longint'(waddr_v[d]), 0);
      check_eq({tag, "_pd"}, longint'(pd_v[d]), 0);
      check_eq({tag, "_ld"}, longint'(ld_v[d]), 0);
      check_eq({tag, "_busy"}, longint'(busy_v[d]), 0);
      check_eq({tag, "_ch"}, longint'(ch_v[d]), 0);
   endtask

   task automatic model_step(input int d);
      int  c = cyc;
      int  n = oc_of(d) * pp_of(d);
      bit  e_rdy = 1'b0;
      int  e_addr = 0;
      bit  e_wr = 1'b0;
      int  e_wa = 0;
      bit  e_pd = 1'b0;
      int  e_ch;
      if (!rst_v[d]) begin
         model_reset(d);
         check_all_zero(d, "in_reset");
         return;
      end
      if (!run_m[d] && (c - 1 >= idle_from_m[d])) begin
         if (st_v[d]) begin
            run_m[d]   = 1'b1;
            beats_m[d] = 0;
            nidx_m[d]  = 0;
         end
      end else if (run_m[d] && mv_v[d]) begin
         beats_m[d]++;
         if (beats_m[d] == acc_of(d)) begin
            beats_m[d] = 0;
            e_rdy  = 1'b1;
            e_addr = nidx_m[d];
            wq_due[d][wq_tl[d] % 16] = c + WD;
            wq_adr[d][wq_tl[d] % 16] = nidx_m[d];
            wq_tl[d]++;
            if (nidx_m[d] == n - 1) begin
               run_m[d]       = 1'b0;
               busy_til_m[d]  = c + WD;
               ld_at_m[d]     = c + WD + 1;
               idle_from_m[d] = c + WD + 2;
            end
            nidx_m[d]++;
         end
      end
      if (wq_hd[d] != wq_tl[d] && wq_due[d][wq_hd[d] % 16] == c) begin
         e_wr = 1'b1;
         e_wa = wq_adr[d][wq_hd[d] % 16];
         e_pd = ((e_wa % pp_of(d)) == pp_of(d) - 1);
         wq_hd[d]++;
      end
      if (run_m[d]) e_ch = nidx_m[d] / pp_of(d);
      else e_ch = (c < idle_from_m[d]) ? oc_of(d) - 1 : 0;

      check_eq("neuron_rdy", longint'(rdy_v[d]), longint'(e_rdy));
      if (e_rdy) check_eq("out_addr", longint'(oaddr_v[d]), e_addr);
      check_eq("wr_en", longint'(wr_v[d]), longint'(e_wr));
      if (e_wr) check_eq("wr_addr", longint'(waddr_v[d]), e_wa);
      check_eq("plane_done", longint'(pd_v[d]), longint'(e_pd));
      check_eq("layer_done", longint'(ld_v[d]), longint'(c == ld_at_m[d]));
      check_eq("busy", longint'(busy_v[d]), longint'(run_m[d] || c <= busy_til_m[d]));
      check_eq("ch_idx", longint'(ch_v[d]), e_ch);

      if (wr_v[d]) begin
         wr_cnt[d]++;
         last_wr[d] = int'(waddr_v[d]);
      end
      if (pd_v[d]) pd_cnt[d]++;
      if (ld_v[d]) ld_cnt[d]++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
         cur_dut = d;
         model_step(d);
      end
   endtask

   task automatic wait_layer(input int d, input int bound);
      bit seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         tick();
         if (ld_v[d]) seen = 1'b1;
      end
      cur_dut = d;
      check_eq("layer_done_seen", longint'(seen), 1);
   endtask

   task automatic check_totals(input int d, input int writes, input int planes, input int layers);
      cur_dut = d;
      check_eq("write_count", wr_cnt[d], writes);
      check_eq("last_wr_addr", last_wr[d], writes - 1);
      check_eq("plane_done_count", pd_cnt[d], planes);
      check_eq("layer_done_count", ld_cnt[d], layers);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      for (int d = 0; d < NDUT; d++) begin
         rst_v[d] = 1'b0;
         st_v[d]  = 1'b0;
         mv_v[d]  = 1'b0;
         model_reset(d);
         wr_cnt[d]  = 0;
         pd_cnt[d]  = 0;
         ld_cnt[d]  = 0;
         last_wr[d] = -1;
      end
      repeat (3) tick();
      for (int d = 0; d < NDUT; d++) rst_v[d] = 1'b1;
      tick();

      // Continuous beats on the small and single-beat instances; start carries a beat too.
      st_v[0] = 1'b1; st_v[1] = 1'b1;
      mv_v[0] = 1'b1; mv_v[1] = 1'b1;
      tick();
      st_v[0] = 1'b0; st_v[1] = 1'b0;
      wait_layer(0, 100);
      repeat (4) tick();
      mv_v[0] = 1'b0; mv_v[1] = 1'b0;
      check_totals(0, 8, 2, 1);
      check_totals(1, 8, 2, 1);

      // Gapped beats with stray starts and beats landing in every state.
      repeat (700) begin
         for (int d = 0; d < 2; d++) begin
            st_v[d] = ($urandom_range(0, 7) == 0);
            mv_v[d] = $urandom_range(0, 1) == 1;
         end
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         st_v[d] = 1'b0;
         mv_v[d] = 1'b0;
      end
      repeat (10) tick();

      // Reset with a write still in the pipe, then a clean layer from address 0.
      st_v[0] = 1'b1; mv_v[0] = 1'b1;
      tick();
      st_v[0] = 1'b0;
      guard = 0;
      while (nidx_m[0] < 2 && guard < 50) begin
         tick();
         guard++;
      end
      cur_dut = 0;
      check_eq("second_rdy_reached", longint'(nidx_m[0]), 2);
      rst_v[0] = 1'b0;
      #1;
      check_all_zero(0, "async_reset");
      repeat (4) tick();
      rst_v[0] = 1'b1;
      mv_v[0]  = 1'b0;
      tick();
      wr_cnt[0] = 0; pd_cnt[0] = 0; ld_cnt[0] = 0;
      st_v[0] = 1'b1; mv_v[0] = 1'b1;
      tick();
      st_v[0] = 1'b0;
      wait_layer(0, 100);
      repeat (4) tick();
      mv_v[0] = 1'b0;
      check_totals(0, 8, 2, 1);

      // Full-size plane geometry.
      st_v[2] = 1'b1; mv_v[2] = 1'b1;
      tick();
      st_v[2] = 1'b0;
      wait_layer(2, 20000);
      repeat (3) tick();
      mv_v[2] = 1'b0;
      check_totals(2, 3136, 16, 1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
